// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial recovery of an adder operand, a = sum - b.
// One bit per clock, LSB first, with valid/ready handshakes on both sides.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   sum/b present
//   in_ready   block can accept a new operation (registered state is idle)
//   sum        minuend, WIDTH+1 bits (adder result)
//   b          subtrahend, WIDTH bits (known operand)
//   out_valid  result present
//   out_ready  consumer accepts the result
//   diff       low WIDTH bits of (sum - b) mod 2^(WIDTH+1)
//   borrow     1 when sum < b
//   overflow   1 when sum - b >= 2^WIDTH
module serial_subtractor #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH:0]   sum,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             overflow
);

  // Counter must reach WIDTH (the index of the last bit).
  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH:0]   s_q, s_d;
  logic [WIDTH:0]   b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             br_q, br_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic             overflow_q, overflow_d;

  logic s_bit, b_bit, d_bit, br_next, last_bit;

  always_comb begin
    s_bit    = s_q[0];
    b_bit    = b_q[0];
    d_bit    = s_bit ^ b_bit ^ br_q;
    br_next  = (~s_bit & b_bit) | (~(s_bit ^ b_bit) & br_q);
    last_bit = (cnt_q == CntW'(WIDTH));
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    s_d        = s_q;
    b_d        = b_q;
    res_d      = res_q;
    br_d       = br_q;
    diff_d     = diff_q;
    borrow_d   = borrow_q;
    overflow_d = overflow_q;

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          s_d     = sum;
          b_d     = {1'b0, b};
          br_d    = 1'b0;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        s_d   = s_q >> 1;
        b_d   = b_q >> 1;
        br_d  = br_next;
        cnt_d = cnt_q + CntW'(1);
        if (last_bit) begin
          // Bit WIDTH is not stored; it only feeds the overflow flag.
          diff_d     = res_q;
          borrow_d   = br_next;
          overflow_d = d_bit & ~br_next;
          state_d    = StDone;
        end else begin
          res_d = (res_q >> 1) | (WIDTH'(d_bit) << (WIDTH - 1));
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      s_q        <= '0;
      b_q        <= '0;
      res_q      <= '0;
      br_q       <= 1'b0;
      diff_q     <= '0;
      borrow_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      s_q        <= s_d;
      b_q        <= b_d;
      res_q      <= res_d;
      br_q       <= br_d;
      diff_q     <= diff_d;
      borrow_q   <= borrow_d;
      overflow_q <= overflow_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign diff      = diff_q;
  assign borrow    = borrow_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (WIDTH=4) with an expected-result queue.
module tb_serial_subtractor;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W:0]   sum = '0;
  logic [W-1:0] b = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] diff;
  logic         borrow;
  logic         overflow;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          t_acc = 0;
  logic [5:0]  sb[$];
  logic [5:0]  exp_r;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .sum      (sum),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .diff     (diff),
    .borrow   (borrow),
    .overflow (overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: {diff[3:0], borrow, overflow}.
  function automatic logic [5:0] model(input logic [4:0] s, input logic [3:0] bb);
    int r;
    logic [4:0] m;
    r = int'(s) - int'(bb);
    m = r[4:0];
    return {m[3:0], (r < 0), (r >= 16)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [4:0] s, input logic [3:0] bb);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_before_accept", 32'(in_ready), 1);
    in_valid = 1'b1;
    sum      = s;
    b        = bb;
    @(negedge clk);
    t_acc    = cyc;
    in_valid = 1'b0;
    sb.push_back(model(s, bb));
    check("in_ready_after_accept", 32'(in_ready), 0);
  endtask

  task automatic wait_out();
    int n;
    n = 0;
    while (!out_valid && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("out_valid_timeout", 32'(out_valid), 1);
    check("latency", 32'(cyc - t_acc), 5);
  endtask

  task automatic pop_and_compare();
    if (sb.size() == 0) begin
      check("scoreboard_empty", 32'(sb.size()), 1);
      exp_r = '0;
    end else begin
      exp_r = sb.pop_front();
    end
    check("diff", 32'(diff), 32'(exp_r[5:2]));
    check("borrow", 32'(borrow), 32'(exp_r[1]));
    check("overflow", 32'(overflow), 32'(exp_r[0]));
  endtask

  // Assumes out_ready=1, so the output handshake happens on the next edge.
  task automatic recv();
    wait_out();
    pop_and_compare();
    @(negedge clk);
    check("out_valid_after_hs", 32'(out_valid), 0);
    check("in_ready_after_hs", 32'(in_ready), 1);
    check("diff_held", 32'(diff), 32'(exp_r[5:2]));
  endtask

  initial begin
    // Reset state; in_valid held high through an edge in reset must be ignored.
    #1;
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_diff", 32'(diff), 0);
    check("rst_borrow", 32'(borrow), 0);
    check("rst_overflow", 32'(overflow), 0);
    in_valid = 1'b1;
    sum      = 5'h1f;
    @(posedge clk);
    #1;
    check("rst_ignores_in_valid", 32'(in_ready), 1);
    in_valid = 1'b0;
    #2 rst_n = 1'b1;

    // Basic cases.
    send(5'b01000, 4'b0101);
    recv();
    send(5'b10000, 4'b0001);
    recv();
    send(5'b01100, 4'b0110);
    recv();
    send(5'b00011, 4'b0101);
    recv();
    send(5'b11111, 4'b0000);
    recv();

    // Backpressure in DONE with new data offered.
    out_ready = 1'b0;
    send(5'h17, 4'h9);
    wait_out();
    pop_and_compare();
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      sum      = 5'(k + 3);
      b        = 4'(k);
      @(negedge clk);
      check("bp_out_valid", 32'(out_valid), 1);
      check("bp_diff", 32'(diff), 32'(exp_r[5:2]));
      check("bp_borrow", 32'(borrow), 32'(exp_r[1]));
      check("bp_in_ready", 32'(in_ready), 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_out_valid", 32'(out_valid), 0);
    check("bp_release_in_ready", 32'(in_ready), 1);
    begin
      int seen;
      seen = 0;
      for (int k = 0; k < 8; k++) begin
        @(negedge clk);
        if (out_valid) seen++;
      end
      check("bp_no_capture", 32'(seen), 0);
    end

    // Asynchronous reset during bit 2 of an operation.
    send(5'h09, 4'h3);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrun_in_ready", 32'(in_ready), 1);
    check("midrun_out_valid", 32'(out_valid), 0);
    check("midrun_diff", 32'(diff), 0);
    check("midrun_borrow", 32'(borrow), 0);
    check("midrun_overflow", 32'(overflow), 0);
    in_valid = 1'b1;
    sum      = 5'h1e;
    @(posedge clk);
    #1;
    check("midrun_rst_ignores_in_valid", 32'(in_ready), 1);
    in_valid = 1'b0;
    #2 rst_n = 1'b1;
    sb.delete();
    send(5'b00101, 4'b0010);
    recv();

    // Exhaustive sweep.
    for (int s = 0; s < 32; s++) begin
      for (int bb = 0; bb < 16; bb++) begin
        send(s[4:0], bb[3:0]);
        recv();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
